// File: rtl/memory_dma_pkg.sv
// -----------------------------------------------------------------------------
// memory_dma_pkg
// Shared definitions for the memory_dma word-copy engine: the controller state
// encoding, the word stride in bytes and the mask that forces byte addresses
// onto a word boundary.
// -----------------------------------------------------------------------------
package memory_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_t;

    localparam logic [31:0] WORD_BYTES      = 32'd4;
    localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/memory_dma_ack_watchdog.sv
// -----------------------------------------------------------------------------
// ack_watchdog
// Counts consecutive cycles a memory request has been left unacknowledged and
// flags expiry on the ACK_TIMEOUT-th stalled cycle, so the owner can abandon the
// request at that edge. The count restarts whenever the request is acknowledged
// or no request is outstanding, which covers every entry to a new request.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   active_i  in   a request is outstanding this cycle
//   ack_i     in   memory acknowledge
//   expired_o out  this cycle is the ACK_TIMEOUT-th consecutive stalled cycle
// -----------------------------------------------------------------------------
module ack_watchdog #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic ack_i,
    output logic expired_o
);

    // The counter only has to reach ACK_TIMEOUT-1: the stall that lands on that
    // value is the last one tolerated.
    localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic [CNT_W-1:0] stall_cnt;

    assign expired_o = active_i && !ack_i && (stall_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!active_i || ack_i || expired_o) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/memory_dma.sv
// -----------------------------------------------------------------------------
// memory_dma
// Word-copy engine acting as the initiator on a single-port memory interface.
// A start pulse in IDLE latches word-aligned source/destination addresses and a
// word count; the engine then alternates one read and one write per word, each
// held until mem_ack_i, and pulses done_o for one cycle when finished.
//
// Optional build macro MEMORY_DMA_TIMEOUT_EN adds an ack watchdog: a request
// unacknowledged for ACK_TIMEOUT cycles sets the sticky err_o and ends the
// transfer. Without it err_o is tied low and the engine waits indefinitely.
//
// Ports:
//   clk, rst            clock / asynchronous active-high reset
//   start_i             start request, honoured only in IDLE
//   src_addr_i          source byte address (bits [1:0] ignored)
//   dst_addr_i          destination byte address (bits [1:0] ignored)
//   len_i               number of 32-bit words to copy
//   busy_o              high in every state but IDLE
//   done_o              one-cycle pulse at the end of a transfer
//   err_o               ack timeout flag, cleared by the next accepted start
//   mem_rd_en_o         read request
//   mem_wr_en_o         write request
//   mem_addr_o          request byte address
//   mem_data_o          write data (0 unless writing)
//   mem_data_i          read data
//   mem_ack_i           request acknowledge
// -----------------------------------------------------------------------------
module memory_dma
    import memory_dma_pkg::*;
#(
    parameter int LEN_WIDTH   = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [31:0]          src_addr_i,
    input  logic [31:0]          dst_addr_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 mem_rd_en_o,
    output logic                 mem_wr_en_o,
    output logic [31:0]          mem_addr_o,
    output logic [31:0]          mem_data_o,
    input  logic [31:0]          mem_data_i,
    input  logic                 mem_ack_i
);

    dma_state_t           state;
    dma_state_t           next_state;
    logic [31:0]          src_q;
    logic [31:0]          dst_q;
    logic [31:0]          data_q;
    logic [LEN_WIDTH-1:0] remaining_q;
    logic                 ack_timeout;

    // Last word: the write being acknowledged is the one with remaining == 1.
    logic last_word;
    assign last_word = (remaining_q == LEN_WIDTH'(1));

`ifdef MEMORY_DMA_TIMEOUT_EN
    logic err_q;

    ack_watchdog #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_ack_watchdog (
        .clk       (clk),
        .rst       (rst),
        .active_i  ((state == READ) || (state == WRITE)),
        .ack_i     (mem_ack_i),
        .expired_o (ack_timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == IDLE && start_i) begin
            err_q <= 1'b0;
        end else if (ack_timeout) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    // ACK_TIMEOUT only matters to the watchdog build.
    localparam int unused_ack_timeout = ACK_TIMEOUT;

    assign ack_timeout = 1'b0;
    assign err_o       = 1'b0;
`endif

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    next_state = (len_i == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (mem_ack_i) begin
                    next_state = WRITE;
                end else if (ack_timeout) begin
                    next_state = DONE;
                end
            end
            WRITE: begin
                if (mem_ack_i) begin
                    next_state = last_word ? DONE : READ;
                end else if (ack_timeout) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Moore outputs decoded from state and the datapath registers.
    always_comb begin
        busy_o      = (state != IDLE);
        done_o      = (state == DONE);
        mem_rd_en_o = 1'b0;
        mem_wr_en_o = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        case (state)
            READ: begin
                mem_rd_en_o = 1'b1;
                mem_addr_o  = src_q;
            end
            WRITE: begin
                mem_wr_en_o = 1'b1;
                mem_addr_o  = dst_q;
                mem_data_o  = data_q;
            end
            default: ;
        endcase
    end

    // Address, count and data buffer. Address sums wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q       <= '0;
            dst_q       <= '0;
            data_q      <= '0;
            remaining_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        src_q       <= src_addr_i & ADDR_ALIGN_MASK;
                        dst_q       <= dst_addr_i & ADDR_ALIGN_MASK;
                        remaining_q <= len_i;
                    end
                end
                READ: begin
                    if (mem_ack_i) begin
                        data_q <= mem_data_i;
                    end
                end
                WRITE: begin
                    if (mem_ack_i) begin
                        src_q       <= src_q + WORD_BYTES;
                        dst_q       <= dst_q + WORD_BYTES;
                        remaining_q <= remaining_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/memory_dma.md
# memory_dma

Word-copy engine that is the initiator side of the single-port memory interface (rd_en / wr_en / addr / data / ack). On a start pulse it copies `len_i` 32-bit words from a source byte address to a destination byte address by alternating read and write requests, waiting for `ack` on each. It sits between a control block (CPU-side register or testbench) and a memory responder, and drives that responder's ports directly.

## Interface
- `LEN_WIDTH`, 16, width of the word-count input and the internal remaining-words counter
- `ACK_TIMEOUT`, 255, maximum cycles to wait for `mem_ack_i` on one request; used only with `MEMORY_DMA_TIMEOUT_EN`

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start_i`  in  1  start request; sampled only in IDLE
- `src_addr_i`  in  32  source byte address; bits [1:0] ignored and forced to 0
- `dst_addr_i`  in  32  destination byte address; bits [1:0] ignored and forced to 0
- `len_i`  in  LEN_WIDTH  number of words to copy
- `busy_o`  out  1  high in every state except IDLE
- `done_o`  out  1  one-cycle pulse when the transfer ends
- `err_o`  out  1  timeout error flag; sticky until the next accepted start
- `mem_rd_en_o`  out  1  read request to the memory
- `mem_wr_en_o`  out  1  write request to the memory
- `mem_addr_o`  out  32  request byte address
- `mem_data_o`  out  32  write data
- `mem_data_i`  in  32  read data from the memory
- `mem_ack_i`  in  1  transaction acknowledge from the memory

## Operation
- States: IDLE, READ, WRITE, DONE. Moore outputs decoded from state and registers.
- IDLE: all `mem_*` outputs 0. On `start_i`=1, latch `src` and `dst` with bits [1:0] cleared, latch `remaining=len_i`, clear `err_o`. If `len_i`=0 go to DONE, otherwise go to READ.
- READ: `mem_rd_en_o`=1, `mem_addr_o`=src. At an edge where `mem_ack_i`=1, capture `mem_data_i` into the data buffer and go to WRITE.
- WRITE: `mem_wr_en_o`=1, `mem_addr_o`=dst, `mem_data_o`=buffer. At an edge where `mem_ack_i`=1: src+=4, dst+=4, remaining-=1. If remaining was 1, go to DONE, otherwise go to READ.
- DONE: `done_o`=1 for exactly one cycle, then return to IDLE.
- `start_i` is ignored outside IDLE, including in DONE.
- `mem_rd_en_o` and `mem_wr_en_o` are never high in the same cycle.
- Address increments wrap modulo 2^32. `0xFFFFFFFC`+4 gives `0x00000000`, and no error is raised.
- `mem_data_o` is 0 whenever `mem_wr_en_o`=0.

## Timing
- Reset values: state=IDLE, `busy_o`=0, `done_o`=0, `err_o`=0, all `mem_*` outputs 0, internal registers 0.
- Reset asserted mid-transfer aborts immediately. No further requests are issued and `done_o` does not pulse.
- With `mem_ack_i` tied to 1:
  - Start accepted at edge 0. READ occupies cycle 1, WRITE occupies cycle 2, and so on.
  - For N words, `busy_o` is high for 2N+1 cycles.
  - `done_o` is high in cycle 2N+1.
- `len_i`=0: `busy_o` and `done_o` are high for one cycle, and no memory requests are issued.
- Each extra cycle with `mem_ack_i`=0 holds the current request stable for one more cycle.

## Configuration
- `MEMORY_DMA_TIMEOUT_EN` defined:
  - A per-request counter resets on every entry to READ or WRITE and increments each cycle `mem_ack_i`=0.
  - When the count reaches `ACK_TIMEOUT`, set `err_o`=1 and go to DONE. The pending word is not counted.
- `MEMORY_DMA_TIMEOUT_EN` not defined:
  - No counter is built, `err_o` is tied to 0, and the block waits for `ack` indefinitely.

## Structure
- Package `memory_dma_pkg` holds:
  - the state enum (IDLE/READ/WRITE/DONE)
  - `WORD_BYTES`=4
  - `ADDR_ALIGN_MASK`=`32'hFFFF_FFFC`
- Sub-module `ack_watchdog` (counter plus compare, `ACK_TIMEOUT` parameter), instantiated only under `MEMORY_DMA_TIMEOUT_EN`.

## Test plan
- Basic copy, ack tied 1: preload src words 0x100..0x10C = 0xA0..0xA3, then start with src=0x100, dst=0x200, len=4 → 0x200..0x20C = 0xA0..0xA3, `done_o` in cycle 9, `busy_o` high for 9 cycles.
- `len_i`=0 → no `rd_en`/`wr_en` ever asserted, single `done_o` pulse one cycle after start.
- Misaligned src=0x103, dst=0x202 → requests use 0x100 and 0x200.
- Ack stalls: hold ack low 3 cycles on each request → request outputs stay stable while stalled, data is still correct, `busy_o` is extended by 6 cycles per word.
- Reset mid-transfer: raise `rst` during the second WRITE → all outputs 0 immediately, word 2 is not written, no `done_o` pulse.
- With `MEMORY_DMA_TIMEOUT_EN` and `ACK_TIMEOUT`=8: ack stuck low → `err_o`=1 and a `done_o` pulse after 8 stalled cycles. A following start with ack restored → `err_o` clears and the copy completes.
